// File: rtl/mem_stage_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : mem_stage_pkg                                          |
// | Description : Shared widths, IO address and data-memory depth for    |
// |               the swt16 memory/write-back stage.                     |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
package mem_stage_pkg;

   localparam int c_dmem_addr_width = 12;
   localparam int c_dmem_word_width = 16;
   localparam int c_ialu_word_width = 16;
   localparam int c_pmem_word_width = 16;
   localparam int c_pc_width        = 12;
   localparam int c_reg_idx_width   = 4;
   localparam logic [c_dmem_addr_width-1:0] c_io_addr = 12'hFFE;

   // One word per pair of byte addresses.
   function automatic int dmem_depth(input int addr_width);
      return 1 << (addr_width - 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/mem_stage_dmem_array.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : dmem_array                                             |
// | Description : Single-clock data RAM, one write and one read port,    |
// |               write-first on same-word collision, no reset.          |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module dmem_array #(
   parameter int ADDR_WIDTH = 11,
   parameter int WORD_WIDTH = 16,
   parameter int DEPTH      = 2048
) (
   input  logic                  clock,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [WORD_WIDTH-1:0] wr_word,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [WORD_WIDTH-1:0] rd_word
);

   logic [WORD_WIDTH-1:0] r_mem [0:DEPTH-1];
   logic [WORD_WIDTH-1:0] r_rd_word;

   // Synchronous write port.
   always_ff @(posedge clock) begin
      if (wr_en) begin
         r_mem[wr_addr] <= wr_word;
      end
   end

   // Synchronous read port; a same-edge write to the same word bypasses the array.
   always_ff @(posedge clock) begin
      if (rd_en) begin
         r_rd_word <= (wr_en && (wr_addr == rd_addr)) ? wr_word : r_mem[rd_addr];
      end
   end

   assign rd_word = r_rd_word;

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : mem_stage                                              |
// | Description : swt16 memory/write-back stage: data memory, IO output  |
// |               register, stage registers and write-back mux.          |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int DMEM_ADDR_WIDTH = c_dmem_addr_width,
   parameter int DMEM_WORD_WIDTH = c_dmem_word_width,
   parameter int IALU_WORD_WIDTH = c_ialu_word_width,
   parameter int PMEM_WORD_WIDTH = c_pmem_word_width,
   parameter int PC_WIDTH        = c_pc_width,
   parameter int REG_IDX_WIDTH   = c_reg_idx_width,
   parameter logic [DMEM_ADDR_WIDTH-1:0] IO_ADDR = c_io_addr
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       in_act_load_dmem,
   input  logic                       in_act_store_dmem,
   input  logic                       in_act_write_res_to_reg,
   input  logic [DMEM_ADDR_WIDTH-1:0] in_dmem_rd_addr,
   input  logic [DMEM_ADDR_WIDTH-1:0] in_dmem_wr_addr,
   input  logic [DMEM_WORD_WIDTH-1:0] in_dmem_wr_word,
   input  logic [IALU_WORD_WIDTH-1:0] in_res,
   input  logic [REG_IDX_WIDTH-1:0]   in_res_reg_idx,
   input  logic [PMEM_WORD_WIDTH-1:0] in_instr,
   input  logic [PC_WIDTH-1:0]        in_pc,
   output logic                       out_wb_en,
   output logic [REG_IDX_WIDTH-1:0]   out_wb_reg_idx,
   output logic [IALU_WORD_WIDTH-1:0] out_wb_data,
   output logic                       out_fwd_valid,
   output logic [IALU_WORD_WIDTH-1:0] out_fwd_data,
   output logic [PMEM_WORD_WIDTH-1:0] out_instr,
   output logic [PC_WIDTH-1:0]        out_pc,
   output logic [DMEM_WORD_WIDTH-1:0] out_io_word,
   output logic                       out_io_valid
);

   localparam int c_idx_width = DMEM_ADDR_WIDTH - 1;
   localparam int c_depth     = dmem_depth(DMEM_ADDR_WIDTH);
   localparam logic [c_idx_width-1:0] c_io_word_idx = IO_ADDR[DMEM_ADDR_WIDTH-1:1];

   // Word indices: byte address bit 0 is dropped for every access.
   logic [c_idx_width-1:0]     w_rd_idx;
   logic [c_idx_width-1:0]     w_wr_idx;
   logic                       w_rd_is_io;
   logic                       w_wr_is_io;
   logic                       w_array_we;
   logic                       w_array_re;
   logic                       w_io_we;
   logic [DMEM_WORD_WIDTH-1:0] w_array_rd_word;
   logic                       w_unused_bits;

   logic                       r_load;
   logic                       r_load_io;
   logic                       r_write_res;
   logic [IALU_WORD_WIDTH-1:0] r_res;
   logic [REG_IDX_WIDTH-1:0]   r_res_reg_idx;
   logic [PMEM_WORD_WIDTH-1:0] r_instr;
   logic [PC_WIDTH-1:0]        r_pc;
   logic [DMEM_WORD_WIDTH-1:0] r_io_word;
   logic                       r_io_valid;

   assign w_rd_idx      = in_dmem_rd_addr[DMEM_ADDR_WIDTH-1:1];
   assign w_wr_idx      = in_dmem_wr_addr[DMEM_ADDR_WIDTH-1:1];
   assign w_unused_bits = in_dmem_rd_addr[0] ^ in_dmem_wr_addr[0];
   assign w_rd_is_io    = (w_rd_idx == c_io_word_idx);
   assign w_wr_is_io    = (w_wr_idx == c_io_word_idx);

   // Reset gates the array write so a store coinciding with reset is dropped.
   assign w_array_we = in_act_store_dmem && !w_wr_is_io && !reset;
   assign w_array_re = in_act_load_dmem && !w_rd_is_io;
   assign w_io_we    = in_act_store_dmem && w_wr_is_io;

   dmem_array #(
      .ADDR_WIDTH (c_idx_width),
      .WORD_WIDTH (DMEM_WORD_WIDTH),
      .DEPTH      (c_depth)
   ) u_dmem_array (
      .clock   (clock),
      .wr_en   (w_array_we),
      .wr_addr (w_wr_idx),
      .wr_word (in_dmem_wr_word),
      .rd_en   (w_array_re),
      .rd_addr (w_rd_idx),
      .rd_word (w_array_rd_word)
   );

   // Stage registers and IO output register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_load        <= 1'b0;
         r_load_io     <= 1'b0;
         r_write_res   <= 1'b0;
         r_res         <= '0;
         r_res_reg_idx <= '0;
         r_instr       <= '0;
         r_pc          <= '0;
         r_io_word     <= '0;
         r_io_valid    <= 1'b0;
      end else begin
         r_load        <= in_act_load_dmem;
         r_load_io     <= in_act_load_dmem && w_rd_is_io;
         r_write_res   <= in_act_write_res_to_reg;
         r_res         <= in_res;
         r_res_reg_idx <= in_res_reg_idx;
         r_instr       <= in_instr;
         r_pc          <= in_pc;
         r_io_valid    <= w_io_we;
         if (w_io_we) begin
            r_io_word <= in_dmem_wr_word;
         end
      end
   end

   // Write-back mux; an IO load reads the IO register as it stands after the
   // load's edge, which already holds a same-edge IO store.
   always_comb begin
      out_wb_data = r_res;
      if (r_load) begin
         out_wb_data = r_load_io ? r_io_word : w_array_rd_word;
      end
   end

   assign out_wb_en      = r_write_res;
   assign out_wb_reg_idx = r_res_reg_idx;
   assign out_fwd_valid  = r_write_res;
   assign out_fwd_data   = out_wb_data;
   assign out_instr      = r_instr;
   assign out_pc         = r_pc;
   assign out_io_word    = r_io_word;
   assign out_io_valid   = r_io_valid;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_mem_stage                                           |
// | Description : Self-checking bench for mem_stage with a word-level    |
// |               memory model and randomized traffic.                   |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module tb_mem_stage;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        ld, st, wr;
   logic [11:0] rd_a, wr_a;
   logic [15:0] wr_w, res;
   logic [3:0]  idx;
   logic [15:0] instr;
   logic [11:0] pc;

   logic        wb_en, fwd_valid, io_valid;
   logic [3:0]  wb_idx;
   logic [15:0] wb_data, fwd_data, o_instr, io_word;
   logic [11:0] o_pc;

   int errors = 0;
   int checks = 0;

   // Model: word-addressed memory, known-flags, IO register.
   logic [15:0] m_mem   [0:2047];
   bit          m_known [0:2047];
   logic [15:0] m_io;

   mem_stage dut (
      .clock                   (clock),
      .reset                   (reset),
      .in_act_load_dmem        (ld),
      .in_act_store_dmem       (st),
      .in_act_write_res_to_reg (wr),
      .in_dmem_rd_addr         (rd_a),
      .in_dmem_wr_addr         (wr_a),
      .in_dmem_wr_word         (wr_w),
      .in_res                  (res),
      .in_res_reg_idx          (idx),
      .in_instr                (instr),
      .in_pc                   (pc),
      .out_wb_en               (wb_en),
      .out_wb_reg_idx          (wb_idx),
      .out_wb_data             (wb_data),
      .out_fwd_valid           (fwd_valid),
      .out_fwd_data            (fwd_data),
      .out_instr               (o_instr),
      .out_pc                  (o_pc),
      .out_io_word             (io_word),
      .out_io_valid            (io_valid)
   );

   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic l, input logic s, input logic w,
                        input logic [11:0] ra, input logic [11:0] wa, input logic [15:0] ww,
                        input logic [15:0] r, input logic [3:0] i);
      ld = l; st = s; wr = w; rd_a = ra; wr_a = wa; wr_w = ww; res = r; idx = i;
      instr = 16'($urandom); pc = 12'($urandom);
   endtask

   task automatic flush_inputs();
      ld = 0; st = 0; wr = 0; rd_a = 0; wr_a = 0; wr_w = 0; res = 0; idx = 0; instr = 0; pc = 0;
   endtask

   task automatic check_all_zero(input string tag);
      check_eq(tag, {wb_en, wb_idx, wb_data, fwd_valid, fwd_data, o_instr, o_pc, io_word, io_valid}, 64'd0);
   endtask

   // Apply the current inputs for one cycle and check the following cycle.
   task automatic step(input string tag);
      logic [15:0] e_data;
      logic [15:0] e_instr;
      logic [11:0] e_pc;
      bit          e_io_valid;
      bit          data_known;
      int          rw, ww_i;
      rw = int'(rd_a) / 2;
      ww_i = int'(wr_a) / 2;
      e_instr = instr;
      e_pc = pc;
      e_io_valid = 0;
      if (st) begin
         if (ww_i == 12'hFFE / 2) begin
            m_io = wr_w;
            e_io_valid = 1;
         end else begin
            m_mem[ww_i] = wr_w;
            m_known[ww_i] = 1;
         end
      end
      data_known = 1;
      e_data = res;
      if (ld) begin
         if (rw == 12'hFFE / 2) e_data = m_io;
         else begin
            e_data = m_mem[rw];
            data_known = m_known[rw];
         end
      end
      @(posedge clock);
      #1;
      check_eq({tag, ".wb_en"}, wb_en, wr);
      check_eq({tag, ".fwd_valid"}, fwd_valid, wr);
      check_eq({tag, ".wb_idx"}, wb_idx, idx);
      check_eq({tag, ".instr_pc"}, {o_instr, o_pc}, {e_instr, e_pc});
      check_eq({tag, ".io"}, {io_word, io_valid}, {m_io, e_io_valid});
      if (data_known) begin
         check_eq({tag, ".wb_data"}, wb_data, e_data);
         check_eq({tag, ".fwd_data"}, fwd_data, e_data);
      end
   endtask

   initial begin
      for (int i = 0; i < 2048; i++) m_known[i] = 0;
      m_io = 16'h0000;
      flush_inputs();
      // Reset asserted with traffic on the inputs.
      drive(1, 1, 1, 12'h040, 12'h040, 16'hDEAD, 16'h7777, 4'd9);
      repeat (3) @(posedge clock);
      #1;
      check_all_zero("reset_hold");
      flush_inputs();
      @(negedge clock);
      reset = 1'b0;
      #1;
      check_all_zero("reset_release");

      // Flushed slot.
      flush_inputs();
      step("flush");

      // ALU pass-through.
      drive(0, 0, 1, 12'h000, 12'h000, 16'h0000, 16'h1234, 4'd3);
      step("alu");

      // Store then load with bit 0 set.
      drive(0, 1, 0, 12'h000, 12'h010, 16'hBEEF, 16'h0000, 4'd0);
      step("st_beef");
      flush_inputs();
      step("gap");
      drive(1, 0, 1, 12'h011, 12'h000, 16'h0000, 16'h0000, 4'd5);
      step("ld_beef");

      // Same-edge collision.
      drive(1, 1, 1, 12'h020, 12'h020, 16'hA5A5, 16'h0000, 4'd6);
      step("collide");

      // IO store, array word 0x7FE untouched, IO load.
      drive(0, 1, 0, 12'h000, 12'h7FE, 16'h5555, 16'h0000, 4'd0);
      step("pre_7fe");
      drive(0, 1, 0, 12'h000, 12'hFFE, 16'h00FF, 16'h0000, 4'd0);
      step("io_st");
      drive(1, 0, 1, 12'h7FE, 12'h000, 16'h0000, 16'h0000, 4'd7);
      step("ld_7fe");
      drive(1, 1, 1, 12'hFFE, 12'hFFE, 16'h0F0F, 16'h0000, 4'd8);
      step("io_collide");
      drive(1, 0, 1, 12'hFFF, 12'h000, 16'h0000, 16'h0000, 4'd2);
      step("io_ld");

      // Preload a small window, then random traffic over it and the IO word.
      for (int i = 0; i < 16; i++) begin
         drive(0, 1, 0, 12'h000, 12'(i * 2), 16'($urandom), 16'h0000, 4'd0);
         step("preload");
      end
      for (int n = 0; n < 300; n++) begin
         logic [11:0] ra, wa;
         ra = ($urandom_range(0, 7) == 0) ? 12'hFFE : 12'($urandom_range(0, 15) * 2);
         wa = ($urandom_range(0, 7) == 0) ? 12'hFFE : 12'($urandom_range(0, 15) * 2);
         ra[0] = 1'($urandom);
         wa[0] = 1'($urandom);
         if ($urandom_range(0, 9) == 0) flush_inputs();
         else drive(1'($urandom), 1'($urandom), 1'($urandom), ra, wa,
                    16'($urandom), 16'($urandom), 4'($urandom));
         step("rand");
      end

      // Reset mid-stream during a store to 0x030.
      drive(0, 1, 0, 12'h000, 12'h030, 16'h2222, 16'h0000, 4'd0);
      step("pre_030");
      drive(0, 1, 1, 12'h000, 12'h030, 16'h1111, 16'h4444, 4'd1);
      reset = 1'b1;
      #1;
      check_all_zero("reset_async");
      @(posedge clock);
      #1;
      check_all_zero("reset_mid");
      flush_inputs();
      @(negedge clock);
      reset = 1'b0;
      m_io = 16'h0000;
      drive(1, 0, 1, 12'h030, 12'h000, 16'h0000, 16'h0000, 4'd4);
      step("ld_030");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
